// File: rtl/fsgn_arbiter.sv
// Two-port round-robin arbiter in front of a single-precision sign-injection unit
// (fsgnj/fsgnjn/fsgnjx/pass), with a one-entry valid/ready result register.
module fsgn_arbiter #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [31:0]      req_x1_0,
  input  logic [31:0]      req_x1_1,
  input  logic [31:0]      req_x2_0,
  input  logic [31:0]      req_x2_1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OP_SGNJ  = 2'b00,
    OP_SGNJN = 2'b01,
    OP_SGNJX = 2'b10,
    OP_PASS  = 2'b11
  } op_e;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              res_src_q, res_src_d;
  logic              last_grant_q, last_grant_d;

  logic              can_accept;
  logic              hs;
  logic              sel;
  logic [1:0]        grant;
  op_e               sel_op;
  logic [DATA_W-1:0] sel_x1;
  logic [DATA_W-1:0] sel_x2;
  logic [TAG_W-1:0]  sel_tag;
  logic              new_sign;

  // Round-robin: a lone requester wins; under contention the port not served last wins.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid;
    end
  end

  assign can_accept = ~res_valid_q | res_ready;
  assign req_ready  = (rst | ~can_accept) ? 2'b00 : grant;
  assign hs         = |req_ready;
  assign sel        = req_ready[1];

  always_comb begin
    sel_op  = op_e'(req_op0);
    sel_x1  = req_x1_0;
    sel_x2  = req_x2_0;
    sel_tag = req_tag0;
    if (sel) begin
      sel_op  = op_e'(req_op1);
      sel_x1  = req_x1_1;
      sel_x2  = req_x2_1;
      sel_tag = req_tag1;
    end
  end

  // Only the sign bit is computed; magnitude bits pass straight from x1.
  always_comb begin
    new_sign = sel_x1[DATA_W-1];
    unique case (sel_op)
      OP_SGNJ:  new_sign = sel_x2[DATA_W-1];
      OP_SGNJN: new_sign = ~sel_x2[DATA_W-1];
      OP_SGNJX: new_sign = sel_x1[DATA_W-1] ^ sel_x2[DATA_W-1];
      OP_PASS:  new_sign = sel_x1[DATA_W-1];
      default:  new_sign = sel_x1[DATA_W-1];
    endcase
  end

  always_comb begin
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    res_src_d    = res_src_q;
    last_grant_d = last_grant_q;
    if (hs) begin
      res_valid_d  = 1'b1;
      res_data_d   = {new_sign, sel_x1[DATA_W-2:0]};
      res_tag_d    = sel_tag;
      res_src_d    = sel;
      last_grant_d = sel;
    end else if (res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  // last_grant resets to 1 so port 0 takes the first contested cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= '0;
      res_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      res_src_q    <= res_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_src   = res_src_q;

endmodule
